// File: rtl/arm_operand2_issue_if.sv
// Operand2 issue bus: upstream request, register-file read port and
// downstream shifter-control result, bundled for the issue stage.
//   master : environment side (drives requests, rf_data, out_ready)
//   slave  : issue stage side (drives in_ready, rf_addr and results)
interface arm_operand2_issue_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AMOUNT_WIDTH = 5
);
    localparam int unsigned OP2_WIDTH = 12;
    localparam int unsigned REG_WIDTH = 4;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_imm;
    logic [OP2_WIDTH-1:0]    in_op2;
    logic                    in_cflag;
    logic [REG_WIDTH-1:0]    rf_addr;
    logic [DATA_WIDTH-1:0]   rf_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              sh_op;
    logic [AMOUNT_WIDTH-1:0] sh_amount;
    logic [DATA_WIDTH-1:0]   sh_in;
    logic                    sh_carry_in;
    logic                    byp;
    logic [DATA_WIDTH-1:0]   byp_value;
    logic                    byp_carry;
    logic                    out_illegal;

    modport master (
        output in_valid, in_imm, in_op2, in_cflag, rf_data, out_ready,
        input  in_ready, rf_addr, out_valid, sh_op, sh_amount, sh_in,
               sh_carry_in, byp, byp_value, byp_carry, out_illegal
    );

    modport slave (
        input  in_valid, in_imm, in_op2, in_cflag, rf_data, out_ready,
        output in_ready, rf_addr, out_valid, sh_op, sh_amount, sh_in,
               sh_carry_in, byp, byp_value, byp_carry, out_illegal
    );
endinterface

// File: rtl/arm_operand2_issue.sv
// ARM data-processing operand2 issue stage. Decodes the operand2 field into
// barrel-shifter controls (or a bypass value for register-shift corner cases).
// Immediates, immediate shifts and illegal encodings take one cycle; register
// shifts take an extra RS_READ cycle to fetch Rs through the shared rf port.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of arm_operand2_issue_if (request, rf port, result)
module arm_operand2_issue #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AMOUNT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arm_operand2_issue_if.slave   bus
);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {IDLE, RS_READ} state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   rm_q, rm_n;
    logic [1:0]              type_q, type_n;
    logic                    cflag_q, cflag_n;
    logic [3:0]              rs_q, rs_n;

    logic                    valid_q, valid_n;
    logic [1:0]              sh_op_q, sh_op_n;
    logic [AMOUNT_WIDTH-1:0] sh_amount_q, sh_amount_n;
    logic [DATA_WIDTH-1:0]   sh_in_q, sh_in_n;
    logic                    sh_carry_in_q, sh_carry_in_n;
    logic                    byp_q, byp_n;
    logic [DATA_WIDTH-1:0]   byp_value_q, byp_value_n;
    logic                    byp_carry_q, byp_carry_n;
    logic                    illegal_q, illegal_n;

    logic                    accept_c;
    logic                    reg_shift_c;
    logic [7:0]              amt_c;

    // rst_n gate keeps in_ready low throughout reset
    assign bus.in_ready = rst_n && (state == IDLE) && (!valid_q || bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign reg_shift_c  = !bus.in_imm && bus.in_op2[4] && !bus.in_op2[7];
    assign amt_c        = bus.rf_data[7:0];
    assign bus.rf_addr  = (state == IDLE) ? bus.in_op2[3:0] : rs_q;

    assign bus.out_valid   = valid_q;
    assign bus.sh_op       = sh_op_q;
    assign bus.sh_amount   = sh_amount_q;
    assign bus.sh_in       = sh_in_q;
    assign bus.sh_carry_in = sh_carry_in_q;
    assign bus.byp         = byp_q;
    assign bus.byp_value   = byp_value_q;
    assign bus.byp_carry   = byp_carry_q;
    assign bus.out_illegal = illegal_q;

    // State, register-shift latches and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rm_q          <= '0;
            type_q        <= '0;
            cflag_q       <= 1'b0;
            rs_q          <= '0;
            valid_q       <= 1'b0;
            sh_op_q       <= '0;
            sh_amount_q   <= '0;
            sh_in_q       <= '0;
            sh_carry_in_q <= 1'b0;
            byp_q         <= 1'b0;
            byp_value_q   <= '0;
            byp_carry_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state         <= state_n;
            rm_q          <= rm_n;
            type_q        <= type_n;
            cflag_q       <= cflag_n;
            rs_q          <= rs_n;
            valid_q       <= valid_n;
            sh_op_q       <= sh_op_n;
            sh_amount_q   <= sh_amount_n;
            sh_in_q       <= sh_in_n;
            sh_carry_in_q <= sh_carry_in_n;
            byp_q         <= byp_n;
            byp_value_q   <= byp_value_n;
            byp_carry_q   <= byp_carry_n;
            illegal_q     <= illegal_n;
        end
    end

    // Next-state, decode and output-register load
    always_comb begin
        state_n       = state;
        rm_n          = rm_q;
        type_n        = type_q;
        cflag_n       = cflag_q;
        rs_n          = rs_q;
        valid_n       = valid_q;
        sh_op_n       = sh_op_q;
        sh_amount_n   = sh_amount_q;
        sh_in_n       = sh_in_q;
        sh_carry_in_n = sh_carry_in_q;
        byp_n         = byp_q;
        byp_value_n   = byp_value_q;
        byp_carry_n   = byp_carry_q;
        illegal_n     = illegal_q;

        if (valid_q && bus.out_ready) begin
            valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (accept_c && reg_shift_c) begin
                    rm_n    = bus.rf_data;
                    type_n  = bus.in_op2[6:5];
                    cflag_n = bus.in_cflag;
                    rs_n    = bus.in_op2[11:8];
                    state_n = RS_READ;
                end else if (accept_c) begin
                    valid_n       = 1'b1;
                    byp_n         = 1'b0;
                    byp_value_n   = '0;
                    byp_carry_n   = 1'b0;
                    illegal_n     = 1'b0;
                    sh_carry_in_n = bus.in_cflag;
                    if (bus.in_imm) begin
                        sh_in_n = DATA_WIDTH'(bus.in_op2[7:0]);
                        if (bus.in_op2[11:8] != 4'd0) begin
                            sh_op_n     = SH_ROR;
                            sh_amount_n = AMOUNT_WIDTH'({bus.in_op2[11:8], 1'b0});
                        end else begin
                            sh_op_n     = SH_LSL;
                            sh_amount_n = '0;
                        end
                    end else if (!bus.in_op2[4]) begin
                        sh_op_n     = bus.in_op2[6:5];
                        sh_amount_n = AMOUNT_WIDTH'(bus.in_op2[11:7]);
                        sh_in_n     = bus.rf_data;
                    end else begin
                        // op2[4]=1 with op2[7]=1 is not a valid shift encoding
                        illegal_n   = 1'b1;
                        sh_op_n     = SH_LSL;
                        sh_amount_n = '0;
                        sh_in_n     = bus.rf_data;
                    end
                end
            end
            RS_READ: begin
                state_n       = IDLE;
                valid_n       = 1'b1;
                illegal_n     = 1'b0;
                byp_n         = 1'b0;
                byp_value_n   = '0;
                byp_carry_n   = 1'b0;
                sh_in_n       = rm_q;
                sh_carry_in_n = cflag_q;
                sh_op_n       = type_q;
                sh_amount_n   = AMOUNT_WIDTH'(amt_c[4:0]);
                if (amt_c == 8'd0) begin
                    sh_op_n     = SH_LSL;
                    sh_amount_n = '0;
                end else begin
                    // amounts >= 32 fold onto shifter encodings or a bypass value
                    case (type_q)
                        SH_LSL: begin
                            if (amt_c >= 8'd32) begin
                                sh_op_n     = SH_LSL;
                                sh_amount_n = '0;
                                byp_n       = 1'b1;
                                byp_carry_n = (amt_c == 8'd32) ? rm_q[0] : 1'b0;
                            end
                        end
                        SH_LSR: begin
                            if (amt_c == 8'd32) begin
                                sh_amount_n = '0;
                            end else if (amt_c > 8'd32) begin
                                sh_op_n     = SH_LSL;
                                sh_amount_n = '0;
                                byp_n       = 1'b1;
                            end
                        end
                        SH_ASR: begin
                            if (amt_c >= 8'd32) begin
                                sh_amount_n = '0;
                            end
                        end
                        SH_ROR: begin
                            if (amt_c[4:0] == 5'd0) begin
                                sh_op_n     = SH_LSL;
                                sh_amount_n = '0;
                                byp_n       = 1'b1;
                                byp_value_n = rm_q;
                                byp_carry_n = rm_q[DATA_WIDTH-1];
                            end
                        end
                    endcase
                end
            end
        endcase
    end
endmodule

// File: doc/arm_operand2_issue.md
ARM_OPERAND2_ISSUE -- requirements
Module: arm_operand2_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have parameter AMOUNT_WIDTH, default 5, shifter amount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand2 request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port in_imm  input  1  I bit: 1 = rotated immediate.
REQ-008 SHALL have port in_op2  input  12  operand2 field, bits [11:0].
REQ-009 SHALL have port in_cflag  input  1  current CPSR C flag.
REQ-010 SHALL have port rf_addr  output  4  register-file read address; rf_data is returned combinationally in the same cycle.
REQ-011 SHALL have port rf_data  input  32  register-file read data.
REQ-012 SHALL have ports out_valid, out_ready (output 1, input 1)  downstream handshake.
REQ-013 SHALL have ports sh_op (output 2), sh_amount (output 5), sh_in (output 32), sh_carry_in (output 1)  barrel-shifter controls: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 = LSL pass, LSR #32, ASR #32, RRX respectively.
REQ-014 SHALL have ports byp (output 1), byp_value (output 32), byp_carry (output 1)  when byp=1, the consumer takes byp_value/byp_carry instead of the shifter result.
REQ-015 SHALL have port out_illegal  output  1  flags the encoding in_imm=0, op2[4]=1, op2[7]=1.

Function
REQ-016 SHALL implement FSM states IDLE and RS_READ, plus one output register stage.
REQ-017 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-018 SHALL drive rf_addr = op2[3:0] (Rm) in IDLE and latched Rs (op2[11:8]) in RS_READ.
REQ-019 Immediate, in_imm=1, rot=op2[11:8], imm8=op2[7:0]: if rot!=0, SHALL emit ROR, amount 2*rot, sh_in={24'b0,imm8}, byp=0.
REQ-020 Immediate with rot=0: SHALL emit LSL, amount 0, sh_in=imm8 zero-extended, sh_carry_in=in_cflag.
REQ-021 Immediate shift, in_imm=0, op2[4]=0: SHALL emit sh_op=op2[6:5], sh_amount=op2[11:7], sh_in=Rm, sh_carry_in=in_cflag, byp=0.
REQ-022 Requests per REQ-019..021 and illegal requests SHALL complete in 1 cycle: out_valid rises on the edge after acceptance.
REQ-023 Register shift, in_imm=0, op2[4]=1, op2[7]=0: on acceptance SHALL latch Rm, type, cflag and Rs index, then go to RS_READ.
REQ-024 In RS_READ, SHALL sample amt=rf_data[7:0], load the output register and return to IDLE; out_valid rises 2 cycles after acceptance.
REQ-025 For register shifts with amt=0: SHALL emit LSL, amount 0, byp=0, for every shift type.
REQ-026 LSL: amt 1..31 SHALL pass through directly; amt=32 SHALL give byp=1, value 0, carry Rm[0]; amt>32 SHALL give byp=1, value 0, carry 0.
REQ-027 LSR: amt 1..31 SHALL pass through directly; amt=32 SHALL emit LSR with amount 0; amt>32 SHALL give byp=1, value 0, carry 0.
REQ-028 ASR: amt 1..31 SHALL pass through directly; amt>=32 SHALL emit ASR with amount 0.
REQ-029 ROR: if amt[4:0]!=0, SHALL emit ROR with amount amt[4:0]; if amt[4:0]==0 and amt!=0, SHALL give byp=1, value Rm, carry Rm[31].
REQ-030 Illegal encoding: SHALL set out_illegal=1 and emit LSL, amount 0 on Rm, carry in_cflag; 1-cycle path.
REQ-031 While out_valid && !out_ready, all out_*/sh_*/byp* outputs SHALL hold stable and no new request SHALL be accepted.
REQ-032 On out_valid && out_ready with a new acceptance in the same cycle, SHALL load the new result with no bubble (1-cycle path).
REQ-033 Non-bypass results SHALL drive byp_value=0, byp_carry=0; out_illegal SHALL be 0 except per REQ-030.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, out_valid=0, and all registered outputs (sh_*, byp*, out_illegal) to 0, independent of clk.
REQ-035 in_ready SHALL be 0 while rst_n is low.
REQ-036 Reset asserted in RS_READ SHALL discard the in-flight request; no output is produced for it.

Verification
REQ-037 Scenario: in_imm=1, op2=12'h1FF -> sh_op=11, sh_amount=2, sh_in=32'h000000FF, byp=0, out_valid 1 cycle after acceptance.
REQ-038 Scenario: in_imm=1, op2=12'h012, cflag=1 -> sh_op=00, sh_amount=0, sh_in=32'h12, sh_carry_in=1.
REQ-039 Scenario: register LSL, Rm=32'h00000001, Rs=32 -> rf_addr = Rm then Rs; byp=1, byp_value=0, byp_carry=1; out_valid 2 cycles after acceptance.
REQ-040 Scenario: register ROR, Rm=32'h80000000, Rs=32'h40 -> byp=1, byp_value=32'h80000000, byp_carry=1; register LSR with Rs=32 -> sh_op=01, sh_amount=0.
REQ-041 Scenario: out_ready low for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; then back-to-back immediates complete one per cycle once out_ready=1.
REQ-042 Scenario: rst_n pulsed low while in RS_READ -> out_valid=0 immediately; after release, in_ready=1 and no stale output appears.
